// File: rtl/dfii_init_pkg.sv
// Shared constants and types for the DFII power-up sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dfii_init_pkg;

    // DFII CSR word offsets from the CSR byte base.
    localparam logic [2:0] OFF_CONTROL  = 3'd0;
    localparam logic [2:0] OFF_COMMAND  = 3'd1;
    localparam logic [2:0] OFF_ISSUE    = 3'd2;
    localparam logic [2:0] OFF_ADDRESS  = 3'd3;
    localparam logic [2:0] OFF_BADDRESS = 3'd4;

    // CONTROL register bits.
    localparam logic [31:0] CTRL_SEL     = 32'h1;  // 1 = hardware owns the PHY
    localparam logic [31:0] CTRL_CKE     = 32'h2;
    localparam logic [31:0] CTRL_ODT     = 32'h4;
    localparam logic [31:0] CTRL_RESET_N = 32'h8;

    // COMMAND register bits.
    localparam logic [31:0] CMD_CS  = 32'h1;
    localparam logic [31:0] CMD_WE  = 32'h2;
    localparam logic [31:0] CMD_CAS = 32'h4;
    localparam logic [31:0] CMD_RAS = 32'h8;

    // ZQCL is signalled by A10 high on a ZQ command.
    localparam logic [31:0] ZQCL_ADDR = 32'h400;

    localparam int         N_STEPS   = 26;
    localparam logic [4:0] STEP_LAST = 5'(N_STEPS - 1);

    typedef enum logic [2:0] {
        DLY_NONE,
        DLY_RESET,
        DLY_CKE,
        DLY_MOD,
        DLY_ZQ
    } dly_sel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT,
        S_MT_WR,
        S_MT_RD,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Width of a counter that must hold 0..m without wrapping (never zero).
    function automatic int cnt_width(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/dfii_init_rom.sv
// Step table: maps a step index to the DFII CSR write performed at that step.
// Latency: purely combinational.
// Backpressure: none; the sequencer only advances the index on bus acknowledge.
// Ports: step (index) -> off (CSR word offset), dat (write data),
//        dly (post-delay selector), last (final step of the DFII sequence).
module dfii_init_rom
    import dfii_init_pkg::*;
#(
    parameter logic [13:0] MR0 = 14'h320,
    parameter logic [13:0] MR1 = 14'h006,
    parameter logic [13:0] MR2 = 14'h200,
    parameter logic [13:0] MR3 = 14'h000
) (
    input  logic [4:0]  step,
    output logic [2:0]  off,
    output logic [31:0] dat,
    output dly_sel_t    dly,
    output logic        last
);

    logic [4:0]  rel;
    logic [31:0] grp_addr;
    logic [31:0] grp_ba;
    logic [31:0] grp_cmd;
    dly_sel_t    grp_dly;

    always_comb begin
        // Steps 5..24 are five groups of ADDRESS, BADDRESS, COMMAND, ISSUE.
        rel      = step - 5'd5;
        grp_addr = '0;
        grp_ba   = '0;
        grp_cmd  = CMD_CS | CMD_WE | CMD_CAS | CMD_RAS;  // MRS
        grp_dly  = DLY_MOD;
        case (rel[4:2])
            3'd0: begin grp_addr = {18'b0, MR2}; grp_ba = 32'd2; end
            3'd1: begin grp_addr = {18'b0, MR3}; grp_ba = 32'd3; end
            3'd2: begin grp_addr = {18'b0, MR1}; grp_ba = 32'd1; end
            3'd3: begin grp_addr = {18'b0, MR0}; grp_ba = 32'd0; end
            default: begin
                grp_addr = ZQCL_ADDR;
                grp_ba   = 32'd0;
                grp_cmd  = CMD_CS | CMD_WE;
                grp_dly  = DLY_ZQ;
            end
        endcase

        off  = OFF_CONTROL;
        dat  = '0;
        dly  = DLY_NONE;
        last = (step == STEP_LAST);
        case (step)
            5'd0: dat = CTRL_CKE | CTRL_ODT | CTRL_RESET_N;
            5'd1: off = OFF_ADDRESS;
            5'd2: off = OFF_BADDRESS;
            5'd3: begin dat = CTRL_ODT | CTRL_RESET_N; dly = DLY_RESET; end
            5'd4: begin dat = CTRL_CKE | CTRL_ODT | CTRL_RESET_N; dly = DLY_CKE; end
            STEP_LAST: dat = CTRL_SEL;
            default: begin
                if (step < STEP_LAST) begin
                    case (rel[1:0])
                        2'd0: begin off = OFF_ADDRESS;  dat = grp_addr; end
                        2'd1: begin off = OFF_BADDRESS; dat = grp_ba;   end
                        2'd2: begin off = OFF_COMMAND;  dat = grp_cmd;  end
                        default: begin off = OFF_ISSUE; dat = 32'd1; dly = grp_dly; end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/dfii_init_sequencer.sv
// Wishbone master that runs the DDR3 DFII power-up sequence and hands control to hardware.
// Latency: one transaction per step, >=1 idle cycle between transactions plus post-delays.
// Backpressure: holds each strobe until wb_ack/wb_err or ACK_TIMEOUT expiry.
// Ports: clk/rst; start (sampled in IDLE/DONE/ERROR); busy/done/error/err_step status;
//        wb_* Wishbone classic master (word address, sel fixed at 4'hF).
// Build option: DFII_INIT_MEMTEST_EN adds a write/read-back check of MEMTEST_BASE after
//        the hand-over (err_step 26 = write failed, 27 = read failed or data mismatch).
module dfii_init_sequencer
    import dfii_init_pkg::*;
#(
    parameter logic [31:0] CSR_BASE        = 32'h0000_9000,
    parameter logic [13:0] MR0             = 14'h320,
    parameter logic [13:0] MR1             = 14'h006,
    parameter logic [13:0] MR2             = 14'h200,
    parameter logic [13:0] MR3             = 14'h000,
    parameter int          T_RESET_CYC     = 50000,
    parameter int          T_CKE_CYC       = 50000,
    parameter int          T_MOD_CYC       = 200,
    parameter int          T_ZQ_CYC        = 200,
    parameter int          ACK_TIMEOUT     = 255,
    parameter logic [31:0] MEMTEST_BASE    = 32'h1000_0000,
    parameter logic [31:0] MEMTEST_PATTERN = 32'hA5A5_5A5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [4:0]  err_step,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_r,
    input  logic        wb_ack,
    input  logic        wb_err
);

    localparam int DLY_W = cnt_width(max4(T_RESET_CYC, T_CKE_CYC, T_MOD_CYC, T_ZQ_CYC));
    localparam int TO_W  = cnt_width(ACK_TIMEOUT);

    localparam logic [DLY_W-1:0] D_RESET  = DLY_W'(T_RESET_CYC);
    localparam logic [DLY_W-1:0] D_CKE    = DLY_W'(T_CKE_CYC);
    localparam logic [DLY_W-1:0] D_MOD    = DLY_W'(T_MOD_CYC);
    localparam logic [DLY_W-1:0] D_ZQ     = DLY_W'(T_ZQ_CYC);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(ACK_TIMEOUT);

    state_t           state;
    logic [4:0]       step;
    logic [DLY_W-1:0] dly_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic [2:0]       rom_off;
    logic [31:0]      rom_dat;
    dly_sel_t         rom_dly;
    logic             rom_last;
    logic [29:0]      rom_adr;
    logic [DLY_W-1:0] dly_val;
    logic             rd_bad;
    logic             finish;

    assign wb_sel = 4'hF;

    dfii_init_rom #(
        .MR0 (MR0),
        .MR1 (MR1),
        .MR2 (MR2),
        .MR3 (MR3)
    ) u_rom (
        .step (step),
        .off  (rom_off),
        .dat  (rom_dat),
        .dly  (rom_dly),
        .last (rom_last)
    );

    assign rom_adr = CSR_BASE[31:2] + 30'(rom_off);

    always_comb begin
        dly_val = '0;
        case (rom_dly)
            DLY_RESET: dly_val = D_RESET;
            DLY_CKE:   dly_val = D_CKE;
            DLY_MOD:   dly_val = D_MOD;
            DLY_ZQ:    dly_val = D_ZQ;
            default:   dly_val = '0;
        endcase
    end

`ifdef DFII_INIT_MEMTEST_EN
    assign rd_bad = (state == S_MT_RD) && wb_ack && (wb_dat_r != MEMTEST_PATTERN);
    assign finish = (state == S_MT_RD);
    logic unused_rom_last;
    assign unused_rom_last = rom_last;
`else
    assign rd_bad = 1'b0;
    assign finish = rom_last;
    logic unused_memtest;
    assign unused_memtest = ^{wb_dat_r, MEMTEST_BASE, MEMTEST_PATTERN};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_step <= '0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_dat_w <= '0;
            dly_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    // step is parked at 0 here, so the ROM already shows step 0.
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_step <= '0;
                        busy     <= 1'b1;
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        wb_we    <= 1'b1;
                        wb_adr   <= rom_adr;
                        wb_dat_w <= rom_dat;
                        to_cnt   <= '0;
                        state    <= S_WRITE;
                    end
                end

                S_WRITE, S_MT_WR, S_MT_RD: begin
                    if (wb_err || rd_bad || (!wb_ack && to_cnt == TO_LIMIT)) begin
                        wb_cyc   <= 1'b0;
                        wb_stb   <= 1'b0;
                        wb_we    <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_step <= step;
                        step     <= '0;
                        state    <= S_ERROR;
                    end else if (wb_ack) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        wb_we  <= 1'b0;
                        if (finish) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            step  <= '0;
                            state <= S_DONE;
                        end else begin
                            // Memory-check steps fall outside the ROM and read DLY_NONE.
                            dly_cnt <= dly_val;
                            step    <= step + 5'd1;
                            state   <= S_WAIT;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (dly_cnt != '0) begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end else begin
                        wb_cyc <= 1'b1;
                        wb_stb <= 1'b1;
                        to_cnt <= '0;
`ifdef DFII_INIT_MEMTEST_EN
                        if (step == 5'(N_STEPS)) begin
                            wb_we    <= 1'b1;
                            wb_adr   <= MEMTEST_BASE[31:2];
                            wb_dat_w <= MEMTEST_PATTERN;
                            state    <= S_MT_WR;
                        end else if (step == 5'(N_STEPS + 1)) begin
                            wb_we    <= 1'b0;
                            wb_adr   <= MEMTEST_BASE[31:2];
                            wb_dat_w <= '0;
                            state    <= S_MT_RD;
                        end else
`endif
                        begin
                            wb_we    <= 1'b1;
                            wb_adr   <= rom_adr;
                            wb_dat_w <= rom_dat;
                            state    <= S_WRITE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dfii_init_sequencer.sv
// Scoreboard bench for dfii_init_sequencer: expected bus transactions are queued at start,
// a monitor pops and checks each strobe (address, data, direction, idle gap).
// A scripted zero-wait slave can inject wb_err or withhold ack on a chosen transaction.
module tb_dfii_init_sequencer;

    localparam int          ACK_TO  = 8;
    localparam logic [31:0] PATTERN = 32'hA5A5_5A5A;

    localparam logic [29:0] EXP_ADR [26] = '{
        30'h2400, 30'h2403, 30'h2404, 30'h2400, 30'h2400,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2403, 30'h2404, 30'h2401, 30'h2402,
        30'h2400};
    localparam logic [31:0] EXP_DAT [26] = '{
        32'h0E, 32'h0, 32'h0, 32'h0C, 32'h0E,
        32'h200, 32'h2, 32'h0F, 32'h1,
        32'h000, 32'h3, 32'h0F, 32'h1,
        32'h006, 32'h1, 32'h0F, 32'h1,
        32'h320, 32'h0, 32'h0F, 32'h1,
        32'h400, 32'h0, 32'h03, 32'h1,
        32'h01};
    localparam int EXP_DLY [26] = '{
        0, 0, 0, 10, 10,
        0, 0, 0, 4,  0, 0, 0, 4,  0, 0, 0, 4,  0, 0, 0, 4,  0, 0, 0, 4,
        0};

    typedef struct {
        int          idx;
        logic [29:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        chk_dat;
        int          gap;
    } txn_t;

    logic        clk, rst, start;
    logic        busy, done, error;
    logic [4:0]  err_step;
    logic        wb_cyc, wb_stb, wb_we;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err;

    txn_t exp_q[$];
    int   n_checks, n_fail;
    int   cycle, last_ack, txn_start, stb_starts, txn_idx;
    int   fault_mode, fault_idx;
    logic in_txn;
    logic [31:0] rd_data;

    dfii_init_sequencer #(
        .T_RESET_CYC (10),
        .T_CKE_CYC   (10),
        .T_MOD_CYC   (4),
        .T_ZQ_CYC    (4),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_step (err_step),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_sel   (wb_sel),
        .wb_dat_r (wb_dat_r),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err)
    );

    assign wb_dat_r = rd_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue steps 0..n-1; a full run also queues the memory check when built in.
    task automatic push_seq(input int n);
        txn_t t;
        for (int i = 0; i < n; i++) begin
            t.idx = i; t.adr = EXP_ADR[i]; t.dat = EXP_DAT[i]; t.we = 1'b1; t.chk_dat = 1'b1;
            t.gap = (i == 0) ? -1 : 1 + EXP_DLY[i-1];
            exp_q.push_back(t);
        end
`ifdef DFII_INIT_MEMTEST_EN
        if (n == 26) begin
            t.idx = 26; t.adr = 30'h0400_0000; t.dat = PATTERN; t.we = 1'b1; t.chk_dat = 1'b1; t.gap = 1;
            exp_q.push_back(t);
            t.idx = 27; t.we = 1'b0; t.chk_dat = 1'b0;
            exp_q.push_back(t);
        end
`endif
    endtask

    task automatic run_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("stb_after_start", {31'b0, wb_stb}, 32'd1);
        chk("done_cleared", {30'b0, done, error}, 32'd0);
    endtask

    task automatic wait_end(input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done || error) begin
                at = cycle;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_end: no done/error within %0d cycles", max_cyc);
        end
    endtask

    // Zero-wait slave: responds in the first strobe cycle.
    initial begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        txn_idx = 0;
        forever begin
            @(posedge clk);
            #2;
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (wb_cyc && wb_stb) begin
                if (fault_mode == 1 && txn_idx == fault_idx) begin
                    wb_err = 1'b1;
                end else if (!(fault_mode == 2 && txn_idx == fault_idx)) begin
                    wb_ack = 1'b1;
                    txn_idx++;
                end
            end
        end
    end

    // Monitor: checks each new strobe against the scoreboard.
    initial begin
        txn_t t;
        in_txn = 1'b0;
        last_ack = 0;
        txn_start = 0;
        stb_starts = 0;
        forever begin
            @(negedge clk);
            if (!rst && wb_cyc && wb_stb && !in_txn) begin
                stb_starts++;
                txn_start = cycle;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: adr 0x%0h with no queued transaction", wb_adr);
                end else begin
                    t = exp_q.pop_front();
                    chk($sformatf("step%0d_adr", t.idx), {2'b0, wb_adr}, {2'b0, t.adr});
                    chk($sformatf("step%0d_we", t.idx), {31'b0, wb_we}, {31'b0, t.we});
                    if (t.chk_dat) chk($sformatf("step%0d_dat", t.idx), wb_dat_w, t.dat);
                    if (t.gap >= 0) chk($sformatf("step%0d_gap", t.idx), cycle - last_ack - 1, t.gap);
                end
            end
            if (wb_cyc && wb_stb && wb_ack) last_ack = cycle;
            in_txn = !rst && wb_stb && !wb_ack && !wb_err;
        end
    end

    initial begin
        int at, s, target;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        fault_mode = 0;
        fault_idx = 0;
        rd_data = PATTERN;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_err_step", {27'b0, err_step}, 32'd0);
        chk("rst_cyc_stb_we", {29'b0, wb_cyc, wb_stb, wb_we}, 32'd0);
        chk("rst_adr", {2'b0, wb_adr}, 32'd0);
        chk("rst_dat_w", wb_dat_w, 32'd0);
        chk("rst_sel", {28'b0, wb_sel}, 32'hF);
        rst = 1'b0;

        // Nominal sequence
        push_seq(26);
        run_start();
        wait_end(2000, at);
        chk("nom_done", {30'b0, done, error}, 32'b10);
        chk("nom_busy", {31'b0, busy}, 32'd0);
        chk("nom_done_latency", at - last_ack, 32'd1);
        chk("nom_queue_empty", exp_q.size(), 32'd0);

        // wb_err on step 9
        push_seq(10);
        fault_mode = 1;
        fault_idx = txn_idx + 9;
        run_start();
        wait_end(2000, at);
        chk("err9_error", {30'b0, done, error}, 32'b01);
        chk("err9_step", {27'b0, err_step}, 32'd9);
        s = stb_starts;
        repeat (20) @(negedge clk);
        chk("err9_no_more_strobes", stb_starts, s);
        chk("err9_queue_empty", exp_q.size(), 32'd0);

        // Step 0 never acknowledged
        push_seq(1);
        fault_mode = 2;
        fault_idx = txn_idx;
        run_start();
        wait_end(200, at);
        chk("to_error", {31'b0, error}, 32'd1);
        chk("to_latency", at - txn_start, ACK_TO + 1);
        chk("to_step", {27'b0, err_step}, 32'd0);
        chk("to_bus_released", {30'b0, wb_cyc, wb_stb}, 32'd0);

        // Restart after error
        fault_mode = 0;
        push_seq(26);
        run_start();
        wait_end(2000, at);
        chk("restart_done", {30'b0, done, error}, 32'b10);
        chk("restart_err_step", {27'b0, err_step}, 32'd0);

        // Reset during the post-delay of step 4
        push_seq(5);
        target = txn_idx + 5;
        run_start();
        for (int i = 0; i < 500 && txn_idx < target; i++) @(negedge clk);
        chk("mid_reached_step4", txn_idx, target);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_status", {27'b0, busy, done, error, wb_cyc, wb_stb}, 32'd0);
        chk("mid_rst_bus", {2'b0, wb_adr} | wb_dat_w | {31'b0, wb_we}, 32'd0);
        rst = 1'b0;
        chk("mid_queue_empty", exp_q.size(), 32'd0);
        push_seq(26);
        run_start();
        wait_end(2000, at);
        chk("mid_restart_done", {30'b0, done, error}, 32'b10);

`ifdef DFII_INIT_MEMTEST_EN
        // Memory check: bad read data, then good read data
        rd_data = 32'h0;
        push_seq(26);
        run_start();
        wait_end(2000, at);
        chk("mt_bad_error", {30'b0, done, error}, 32'b01);
        chk("mt_bad_step", {27'b0, err_step}, 32'd27);
        rd_data = PATTERN;
        push_seq(26);
        run_start();
        wait_end(2000, at);
        chk("mt_good_done", {30'b0, done, error}, 32'b10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
